// File: rtl/dice_pkg.sv
// rtl/dice_pkg.sv - shared die constants and legal-roll range check
package dice_pkg;

    localparam int DIE_VALUE_W = 8;

    localparam int unsigned DIE_MAX_D4  = 4;
    localparam int unsigned DIE_MAX_D6  = 6;
    localparam int unsigned DIE_MAX_D8  = 8;
    localparam int unsigned DIE_MAX_D20 = 20;

    localparam int unsigned ROLL_MAX = DIE_MAX_D20;

    function automatic logic roll_in_range(input int unsigned v);
        return (v >= 32'd1) && (v <= ROLL_MAX);
    endfunction

endpackage

// File: rtl/dice_log_ring.sv
// rtl/dice_log_ring.sv - overwrite-on-full ring history with one-cycle pop latency
module dice_log_ring #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic                     rd_valid_o,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     ovf_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    logic is_full, is_empty, pop_go, ovf_go;

    always_comb begin
        is_full  = (level_q == LVL_W'(DEPTH));
        is_empty = (level_q == '0);
        pop_go   = pop_i && !is_empty;
        // A push into a full buffer with no pop drops the oldest entry.
        ovf_go   = push_i && is_full && !pop_go;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;

        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_go || ovf_go) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (pop_go) begin
                rd_valid_d = 1'b1;
                rd_data_d  = mem_q[rd_ptr_q];
            end
            if (push_i && !pop_go && !is_full) begin
                level_d = level_q + 1'b1;
            end else if (pop_go && !push_i) begin
                level_d = level_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !clear_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign level_o    = level_q;
    assign ovf_o      = ovf_go && !clear_i;

endmodule

// File: rtl/dice_roll_log.sv
// rtl/dice_roll_log.sv - roll capture, range check, running statistics and history
module dice_roll_log
    import dice_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int VALUE_W = DIE_VALUE_W,
    parameter int SUM_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic [VALUE_W-1:0]       in_value,
    input  logic                     rd_req,
    input  logic                     clear,
    output logic                     rd_valid,
    output logic [VALUE_W-1:0]       rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full,
    output logic [15:0]              roll_count,
    output logic [SUM_W-1:0]         total,
    output logic [VALUE_W-1:0]       max_value,
    output logic                     overflow,
    output logic                     bad_value
);

    logic               legal, accept, ovf_evt;
    logic [SUM_W:0]     sum_wide;
    logic [15:0]        count_q, count_d;
    logic [SUM_W-1:0]   total_q, total_d;
    logic [VALUE_W-1:0] max_q, max_d;
    logic               overflow_q, overflow_d;
    logic               bad_q, bad_d;

    dice_log_ring #(
        .DEPTH (DEPTH),
        .WIDTH (VALUE_W)
    ) u_ring (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear_i     (clear),
        .push_i      (accept),
        .push_data_i (in_value),
        .pop_i       (rd_req),
        .rd_valid_o  (rd_valid),
        .rd_data_o   (rd_data),
        .level_o     (level),
        .ovf_o       (ovf_evt)
    );

    always_comb begin
        legal    = roll_in_range(32'(in_value));
        accept   = in_valid && legal;
        sum_wide = {1'b0, total_q} + (SUM_W + 1)'(in_value);

        count_d    = count_q;
        total_d    = total_q;
        max_d      = max_q;
        overflow_d = overflow_q | ovf_evt;
        bad_d      = bad_q | (in_valid && !legal);

        if (clear) begin
            count_d    = '0;
            total_d    = '0;
            max_d      = '0;
            overflow_d = 1'b0;
            bad_d      = 1'b0;
        end else if (accept) begin
            // Both counters clamp at all-ones rather than wrapping.
            count_d = (count_q == '1) ? count_q : count_q + 1'b1;
            total_d = sum_wide[SUM_W] ? '1 : sum_wide[SUM_W-1:0];
            max_d   = (in_value > max_q) ? in_value : max_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q    <= '0;
            total_q    <= '0;
            max_q      <= '0;
            overflow_q <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            total_q    <= total_d;
            max_q      <= max_d;
            overflow_q <= overflow_d;
            bad_q      <= bad_d;
        end
    end

    assign empty      = (level == '0);
    assign full       = (level == ($clog2(DEPTH) + 1)'(DEPTH));
    assign roll_count = count_q;
    assign total      = total_q;
    assign max_value  = max_q;
    assign overflow   = overflow_q;
    assign bad_value  = bad_q;

endmodule

// File: doc/dice_roll_log.md
# dice_roll_log

Downstream consumer of the dice roller: captures each finished roll on a single-cycle valid strobe, keeps the most recent DEPTH results in a ring-buffer history, and maintains running statistics (roll count, saturating total, maximum). History entries are read back oldest-first through a one-cycle-latency request port, for use by the display and host-readout logic.

## Interface
- DEPTH, 8: history entries; power of two, 2..64
- VALUE_W, 8: roll value width; matches roller output
- SUM_W, 16: running total width
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  one-cycle strobe; in_value holds a finished roll
- in_value  in  VALUE_W  roll result, legal range 1..20
- rd_req  in  1  pop oldest history entry
- clear  in  1  synchronous flush of history and statistics
- rd_valid  out  1  one-cycle strobe; rd_data is valid
- rd_data  out  VALUE_W  popped entry
- level  out  $clog2(DEPTH)+1  entries held
- empty / full  out  1  level==0 / level==DEPTH
- roll_count  out  16  accepted rolls, saturating at 16'hFFFF
- total  out  SUM_W  sum of accepted rolls, saturating at all-ones
- max_value  out  VALUE_W  largest accepted roll; 0 if none
- overflow  out  1  sticky: history entry overwritten
- bad_value  out  1  sticky: in_value outside 1..20 was presented

## Operation
- Reset: every output 0; empty=1; pointers 0.
- Accept: in_valid=1 and in_value in 1..20 → push to history, roll_count+1, total+=in_value, max_value=max(max_value, in_value).
- Reject: in_valid=1 and in_value==0 or >20 → no push, statistics unchanged, bad_value←1.
- Saturation: roll_count and total clamp at all-ones; never wrap.
- Push when full, no pop: oldest entry overwritten (read pointer advances with write pointer), level stays DEPTH, overflow←1.
- Pop: rd_req=1 and not empty → oldest entry on rd_data next cycle with rd_valid=1; level−1.
- Pop when empty: ignored, rd_valid=0, no error flag.
- Same-cycle accepted push and pop:
  - not empty: both performed; level unchanged.
  - empty: pop ignored; push performed; level becomes 1.
  - full: pop returns the oldest entry, push fills its slot; overflow not set.
- clear=1: pointers, level, roll_count, total, max_value, overflow, bad_value → 0; overrides in_valid and rd_req in the same cycle; rd_valid=0 the following cycle.
- rd_data holds its last value when rd_valid=0.
- Pointers wrap modulo DEPTH.

## Timing
- All state changes occur on the rising clk edge after the inputs are sampled.
- Statistics, level, empty, full and flags reflect a push one cycle after in_valid.
- Read latency is 1 cycle, from rd_req edge to rd_valid/rd_data; back-to-back rd_req yields one entry per cycle.
- in_valid is accepted every cycle; there is no backpressure.
- reset_n assertion mid-operation clears all state immediately, asynchronously; release is synchronised externally.

## Structure
- Shared package dice_pkg:
  - DIE_VALUE_W
  - DIE_MAX_D4/D6/D8/D20 face-count constants
  - ROLL_MAX = 20, used for the legal-range check
- Sub-module dice_log_ring:
  - storage array, read/write pointers, level, overwrite-on-full logic
  - push/pop in; rd_data, rd_valid, level, overflow-event out
- Top level holds the range check, statistics registers and sticky flags.

## Test plan
- Reset, then push 3,6,1 → level=3, roll_count=3, total=10, max_value=6; three rd_req → rd_data 3,6,1 on consecutive cycles, then empty=1.
- Push 9 values 1..9 (DEPTH=8) → full=1, overflow=1, level=8; drain → 2..9.
- Full buffer, same-cycle push 15 and rd_req → rd_data = oldest, level stays 8, overflow stays 0; last entry read is 15.
- in_value 0 and 21 with in_valid → bad_value=1, roll_count and level unchanged; rd_req while empty → rd_valid=0.
- Preload total=65530, push 20 → total=65535; with roll_count at 65535, push 1 → roll_count stays 65535.
- clear asserted in the same cycle as in_valid=1 and rd_req=1 → next cycle all statistics and flags are 0, empty=1, rd_valid=0; assert reset_n low mid-drain → outputs 0 immediately.
